// File: rtl/mem_pipelined_be.sv
// Single-port byte-strobed memory with a READ_LATENCY-deep read pipeline, write acknowledge and
// out-of-range error flag. Define MEM_PARITY_EN to add per-byte even parity and the par_err port.
module mem_pipelined_be #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    wr,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    valid_out,
    output logic                    wr_ack,
    output logic                    err_out
`ifdef MEM_PARITY_EN
    ,
    output logic                    par_err
`endif
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    generate
        if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_data_width
            $error("mem_pipelined_be: DATA_WIDTH must be a positive multiple of 8");
        end
        if (DEPTH < 1 || (ADDR_WIDTH < 62 && (64'(DEPTH) > (64'd1 << ADDR_WIDTH)))) begin : g_bad_depth
            $error("mem_pipelined_be: DEPTH must be in 1..2**ADDR_WIDTH");
        end
        if (READ_LATENCY < 1 || READ_LATENCY > 8) begin : g_bad_latency
            $error("mem_pipelined_be: READ_LATENCY must be in 1..8");
        end
    endgenerate

    logic [DATA_WIDTH-1:0]   mem_reg [DEPTH];
    logic                    in_range;
    logic [IDX_W-1:0]        addr_idx;
    logic                    wr_fire;
    logic                    rd_fire;
    logic [DATA_WIDTH-1:0]   rd_word;

    assign in_range = ({1'b0, addr} < DEPTH_EXT);
    assign addr_idx = addr[IDX_W-1:0];
    assign wr_fire  = en & wr;
    assign rd_fire  = en & ~wr;
    assign rd_word  = in_range ? mem_reg[addr_idx] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (wr_fire && in_range) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) begin
                    mem_reg[addr_idx][8*b +: 8] <= data_in[8*b +: 8];
                end
            end
        end
    end

    logic wr_ack_reg;
    logic wr_err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ack_reg <= 1'b0;
            wr_err_reg <= 1'b0;
        end else begin
            wr_ack_reg <= wr_fire;
            wr_err_reg <= wr_fire & ~in_range;
        end
    end

    // Stage 0 captures the word at the accept edge; later stages only shift, so rewrites
    // of the location never disturb reads already in flight.
    logic [READ_LATENCY-1:0] pipe_valid_reg;
    logic [READ_LATENCY-1:0] pipe_err_reg;
    logic [DATA_WIDTH-1:0]   pipe_data_reg [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   data_hold_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_valid_reg <= '0;
            pipe_err_reg   <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_data_reg[i] <= '0;
            end
        end else begin
            pipe_valid_reg[0] <= rd_fire;
            pipe_err_reg[0]   <= rd_fire & ~in_range;
            pipe_data_reg[0]  <= rd_word;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_valid_reg[i] <= pipe_valid_reg[i-1];
                pipe_err_reg[i]   <= pipe_err_reg[i-1];
                pipe_data_reg[i]  <= pipe_data_reg[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_hold_reg <= '0;
        end else if (pipe_valid_reg[READ_LATENCY-1]) begin
            data_hold_reg <= pipe_data_reg[READ_LATENCY-1];
        end
    end

    assign valid_out = pipe_valid_reg[READ_LATENCY-1];
    assign data_out  = valid_out ? pipe_data_reg[READ_LATENCY-1] : data_hold_reg;
    assign wr_ack    = wr_ack_reg;
    // A completing read owns err_out; a coinciding write ack loses its error indication.
    assign err_out   = valid_out ? pipe_err_reg[READ_LATENCY-1] : (wr_ack_reg & wr_err_reg);

`ifdef MEM_PARITY_EN
    logic [NB-1:0]           par_mem_reg [DEPTH];
    logic [NB-1:0]           wr_par;
    logic [NB-1:0]           rd_calc_par;
    logic [NB-1:0]           rd_stored_par;
    logic                    rd_par_bad;
    logic [READ_LATENCY-1:0] pipe_par_reg;

    for (genvar gi = 0; gi < NB; gi++) begin : g_par
        assign wr_par[gi]      = ^data_in[8*gi +: 8];
        assign rd_calc_par[gi] = ^rd_word[8*gi +: 8];
    end

    assign rd_stored_par = in_range ? par_mem_reg[addr_idx] : '0;
    assign rd_par_bad    = in_range && (rd_calc_par != rd_stored_par);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                par_mem_reg[i] <= '0;
            end
        end else if (wr_fire && in_range) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) begin
                    par_mem_reg[addr_idx][b] <= wr_par[b];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_par_reg <= '0;
        end else begin
            pipe_par_reg[0] <= rd_fire & rd_par_bad;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_par_reg[i] <= pipe_par_reg[i-1];
            end
        end
    end

    assign par_err = pipe_par_reg[READ_LATENCY-1];
`endif

endmodule

// File: tb/tb_mem_pipelined_be.sv
// Scoreboard bench for mem_pipelined_be: two instances (latency 1 and 3) share one random stimulus
// stream; an array-based reference model predicts responses, a negedge monitor checks them.
module tb_mem_pipelined_be;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int NB    = DW / 8;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        logic          par;
        int            due;
    } rd_t;

    typedef struct {
        logic err;
        int   due;
    } wr_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          en    = 1'b0;
    logic          wr    = 1'b0;
    logic [AW-1:0] addr  = '0;
    logic [NB-1:0] be    = '0;
    logic [DW-1:0] data_in = '0;

    logic [DW-1:0] data_out_a, data_out_b;
    logic          valid_a, valid_b, ack_a, ack_b, err_a, err_b, par_a, par_b;

    int            cyc = 0;
    int            n_cmp = 0;
    int            n_bad = 0;
    rd_t           rd_q [2][$];
    wr_t           wr_q [2][$];
    logic [DW-1:0] last_data [2];
    logic [DW-1:0] mem_m [DEPTH];
    bit            corrupt [DEPTH];

    mem_pipelined_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .READ_LATENCY(LAT_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .wr(wr), .addr(addr), .be(be), .data_in(data_in),
        .data_out(data_out_a), .valid_out(valid_a), .wr_ack(ack_a), .err_out(err_a)
`ifdef MEM_PARITY_EN
        , .par_err(par_a)
`endif
    );

    mem_pipelined_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .READ_LATENCY(LAT_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .wr(wr), .addr(addr), .be(be), .data_in(data_in),
        .data_out(data_out_b), .valid_out(valid_b), .wr_ack(ack_b), .err_out(err_b)
`ifdef MEM_PARITY_EN
        , .par_err(par_b)
`endif
    );

`ifndef MEM_PARITY_EN
    assign par_a = 1'b0;
    assign par_b = 1'b0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic check_port(input int p, input logic v, input logic wa, input logic e,
                              input logic [DW-1:0] d, input logic pe);
        rd_t  r;
        wr_t  w;
        logic exp_wa, exp_v, exp_e;
        // Entries whose slot passed unseen were already reported by the valid/ack compare.
        while (rd_q[p].size() > 0 && rd_q[p][0].due < cyc) void'(rd_q[p].pop_front());
        while (wr_q[p].size() > 0 && wr_q[p][0].due < cyc) void'(wr_q[p].pop_front());
        exp_wa = (wr_q[p].size() > 0) && (wr_q[p][0].due == cyc);
        exp_v  = (rd_q[p].size() > 0) && (rd_q[p][0].due == cyc);
        exp_e  = 1'b0;
        chk($sformatf("wr_ack[%0d]", p), DW'(wa), DW'(exp_wa));
        chk($sformatf("valid_out[%0d]", p), DW'(v), DW'(exp_v));
        if (exp_wa) begin
            w = wr_q[p].pop_front();
            exp_e = w.err;
            $display("cyc=%0d dut%0d write ack err=%b", cyc, p, wa ? e : 1'b0);
        end
        if (exp_v) begin
            r = rd_q[p].pop_front();
            exp_e = r.err;
            last_data[p] = r.data;
            chk($sformatf("data_out[%0d]", p), d, r.data);
            chk($sformatf("par_err[%0d]", p), DW'(pe), DW'(r.par));
            $display("cyc=%0d dut%0d read data=%h err=%b par=%b", cyc, p, d, e, pe);
        end else begin
            chk($sformatf("data_hold[%0d]", p), d, last_data[p]);
        end
        chk($sformatf("err_out[%0d]", p), DW'(e), DW'(exp_e));
    endtask

    always @(negedge clk) begin
        check_port(0, valid_a, ack_a, err_a, data_out_a, par_a);
        check_port(1, valid_b, ack_b, err_b, data_out_b, par_b);
    end

    // Drives one request (or idle cycle) and records the predicted responses.
    task automatic op(input logic e, input logic w, input logic [AW-1:0] a,
                      input logic [NB-1:0] b, input logic [DW-1:0] d);
        rd_t r;
        wr_t wt;
        bit  inr;
        int  ai;
        en = e; wr = w; addr = a; be = b; data_in = d;
        inr = (a < DEPTH);
        ai  = inr ? int'(a) : 0;
        if (e && w) begin
            wt.err = !inr;
            wt.due = cyc + 1;
            wr_q[0].push_back(wt);
            wr_q[1].push_back(wt);
            if (inr) begin
                for (int k = 0; k < NB; k++)
                    if (b[k]) mem_m[ai][8*k +: 8] = d[8*k +: 8];
                if (b[0]) corrupt[ai] = 1'b0;
            end
        end else if (e) begin
            r.data = inr ? mem_m[ai] : '0;
            r.err  = !inr;
            r.par  = inr && corrupt[ai];
            r.due  = cyc + LAT_A;
            rd_q[0].push_back(r);
            r.due  = cyc + LAT_B;
            rd_q[1].push_back(r);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int ncyc);
        rst_n = 1'b0;
        en = 1'b0;
        for (int p = 0; p < 2; p++) begin
            rd_q[p].delete();
            wr_q[p].delete();
            last_data[p] = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            mem_m[i] = '0;
            corrupt[i] = 1'b0;
        end
        repeat (ncyc) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) op(1'b0, 1'b0, '0, '0, '0);
    endtask

    initial begin
        #1;
        do_reset(3);

        for (int a = 0; a < DEPTH; a++) op(1'b1, 1'b0, AW'(a), '0, '0);
        idle(4);

        op(1'b1, 1'b1, 32'd3, 4'hF, 32'hDEADBEEF);
        op(1'b1, 1'b1, 32'd3, 4'b0101, 32'h11223344);
        op(1'b1, 1'b0, 32'd3, '0, '0);
        op(1'b1, 1'b0, 32'd1, '0, '0);
        op(1'b1, 1'b0, 32'd2, '0, '0);
        op(1'b1, 1'b0, 32'd5, '0, '0);
        op(1'b1, 1'b1, 32'd5, 4'b0000, 32'hFFFFFFFF);
        idle(4);

        op(1'b1, 1'b1, 32'd16, 4'hF, 32'hA5A5A5A5);
        op(1'b1, 1'b0, 32'd20, '0, '0);
        op(1'b1, 1'b0, 32'hFFFF_FFF0, '0, '0);
        for (int a = 0; a < DEPTH; a++) op(1'b1, 1'b0, AW'(a), '0, '0);
        idle(4);

        repeat (600) begin
            op($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, AW'($urandom_range(0, 19)),
               NB'($urandom), $urandom);
        end
        idle(5);

`ifdef MEM_PARITY_EN
        dut_a.par_mem_reg[7][0] = ~dut_a.par_mem_reg[7][0];
        dut_b.par_mem_reg[7][0] = ~dut_b.par_mem_reg[7][0];
        corrupt[7] = 1'b1;
        op(1'b1, 1'b0, 32'd7, '0, '0);
        op(1'b1, 1'b0, 32'd8, '0, '0);
        op(1'b1, 1'b1, 32'd7, 4'hF, 32'h0F0F0F01);
        op(1'b1, 1'b0, 32'd7, '0, '0);
        idle(5);
`endif

        op(1'b1, 1'b0, 32'd1, '0, '0);
        op(1'b1, 1'b0, 32'd2, '0, '0);
        do_reset(3);
        for (int a = 0; a < DEPTH; a++) op(1'b1, 1'b0, AW'(a), '0, '0);
        idle(6);

        chk("drain_rd0", DW'(rd_q[0].size()), '0);
        chk("drain_rd1", DW'(rd_q[1].size()), '0);
        chk("drain_wr0", DW'(wr_q[0].size()), '0);
        chk("drain_wr1", DW'(wr_q[1].size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
